// File: rtl/sp_ram.sv
// Synchronous single-port RAM: one shared address, active-low chip select and a
// write/read strobe. Read data is registered and held until the next read.
module sp_ram #(
  parameter int unsigned WD = 8,
  parameter int unsigned DP = 16,
  localparam int unsigned AW = $clog2(DP)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cs_n,
  input  logic          w_r_n,
  input  logic [AW-1:0] addr,
  input  logic [WD-1:0] din,
  output logic [WD-1:0] dout
);

  logic [WD-1:0] mem [DP];
  logic [WD-1:0] dout_q;
  logic          wr_en;
  logic          rd_en;

  // rst_n gates writes so the array is frozen while reset is held.
  assign wr_en = rst_n && !cs_n && w_r_n;
  assign rd_en = !cs_n && !w_r_n;

  // The storage array has no reset; its contents survive rst_n.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[addr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= '0;
    end else if (rd_en) begin
      dout_q <= mem[addr];
    end
  end

  assign dout = dout_q;

endmodule

// File: tb/tb_sp_ram.sv
// Directed bench for sp_ram: a vector table for fill/read/deselect/back-to-back
// plus hand-written reset sequences.
module tb_sp_ram;

  logic       clk;
  logic       rst_n;
  logic       cs_n;
  logic       w_r_n;
  logic [3:0] addr;
  logic [7:0] din;
  logic [7:0] dout;

  int unsigned n_vec;
  int unsigned n_err;

  typedef struct {
    logic       cs_n;
    logic       w_r_n;
    logic [3:0] addr;
    logic [7:0] din;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];

  sp_ram #(
    .WD(8),
    .DP(16)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .cs_n (cs_n),
    .w_r_n(w_r_n),
    .addr (addr),
    .din  (din),
    .dout (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: dout=%h expected %h", name, act, exp);
    end
  endtask

  function automatic void add(input logic c, input logic w, input logic [3:0] a,
                              input logic [7:0] d, input logic [7:0] e);
    vec_t v;
    v.cs_n = c; v.w_r_n = w; v.addr = a; v.din = d; v.exp = e;
    vecs.push_back(v);
  endfunction

  // Drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic cyc(input logic c, input logic w, input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    cs_n = c; w_r_n = w; addr = a; din = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    cs_n = 1'b1; w_r_n = 1'b0; addr = '0; din = '0;
    rst_n = 1'b1;

    // Sequential fill, then read back 15 down to 0.
    for (int k = 0; k < 16; k++) add(1'b0, 1'b1, 4'(k), 8'(8'hA0 + k), 8'h00);
    for (int k = 15; k >= 0; k--) add(1'b0, 1'b0, 4'(k), 8'h00, 8'(8'hA0 + k));
    // Deselect holds dout and blocks the write.
    add(1'b0, 1'b0, 4'd5, 8'h00, 8'hA5);
    for (int k = 0; k < 3; k++) add(1'b1, 1'b1, 4'd5, 8'hFF, 8'hA5);
    add(1'b0, 1'b0, 4'd5, 8'h00, 8'hA5);
    // Write leaves dout alone; next read sees the new value.
    add(1'b0, 1'b0, 4'd3, 8'h00, 8'hA3);
    add(1'b0, 1'b1, 4'd3, 8'h3C, 8'hA3);
    add(1'b0, 1'b0, 4'd3, 8'h00, 8'h3C);
    // Back-to-back write then read of the same address.
    add(1'b0, 1'b1, 4'd15, 8'h77, 8'h3C);
    add(1'b0, 1'b0, 4'd15, 8'h00, 8'h77);

    #1 rst_n = 1'b0;
    #1 chk("reset_initial", dout, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Load 0x5A into dout, then assert reset asynchronously mid-cycle.
    cyc(1'b0, 1'b1, 4'd0, 8'h5A);
    cyc(1'b0, 1'b0, 4'd0, 8'h00);
    chk("preload_5a", dout, 8'h5A);
    @(negedge clk);
    cs_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 chk("reset_async", dout, 8'h00);
    repeat (2) @(posedge clk);
    #1 chk("reset_held", dout, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b1, 1'b0, 4'd0, 8'h00);
    chk("reset_release_idle", dout, 8'h00);

    foreach (vecs[i]) begin
      cyc(vecs[i].cs_n, vecs[i].w_r_n, vecs[i].addr, vecs[i].din);
      chk($sformatf("vec%0d", i), dout, vecs[i].exp);
    end

    // Reset retention: a write attempted during reset must not land.
    cyc(1'b0, 1'b1, 4'd9, 8'h99);
    chk("ret_write", dout, 8'h77);
    @(negedge clk);
    cs_n = 1'b0; w_r_n = 1'b1; addr = 4'd9; din = 8'h11;
    rst_n = 1'b0;
    #1 chk("ret_reset_async", dout, 8'h00);
    repeat (2) @(posedge clk);
    #1 chk("ret_reset_held", dout, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    cs_n = 1'b0; w_r_n = 1'b0; addr = 4'd9; din = 8'h00;
    @(posedge clk);
    #1 chk("ret_read_9", dout, 8'h99);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sp_ram.md
# sp_ram

Parameterized synchronous single-port RAM with one shared address bus, active-low chip select and a single write/read direction strobe. It provides generic on-chip storage of DP words of WD bits for register files, small buffers and scratchpads. Writes and reads are synchronous to the rising clock edge. Read data is registered and held until the next read.

## Interface
- WD, default 8: data word width in bits.
- DP, default 16: depth in words. Power of two, ≥ 2.
- AW (derived, not overridable): address width = clog2(DP), which is 4 for the default depth.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low. Clears the output register only.
- cs_n  input  1  chip select, active-low. When high, the RAM is idle.
- w_r_n  input  1  direction strobe: 1 = write, 0 = read. Sampled only while cs_n = 0.
- addr  input  AW  word address, 0 … DP-1.
- din  input  WD  write data.
- dout  output  WD  registered read data.

## Operation
- Storage is an array of DP × WD bits. It has no reset and its power-up contents are undefined.
- Write: at a rising clk edge with cs_n=0 and w_r_n=1, mem[addr] ← din. dout is unchanged.
- Read: at a rising clk edge with cs_n=0 and w_r_n=0, dout ← mem[addr], the value stored before this edge.
- Idle: at a rising clk edge with cs_n=1, there is no memory access and dout holds its value. w_r_n, addr and din are don't-care.
- Write and read are mutually exclusive per cycle, so there is no read-during-write case on the port.
- Read-after-write to the same address on the next cycle returns the newly written data.
- Full address range 0 … DP-1 is valid, with no wrap logic needed because addr is exactly AW bits wide.
- Inputs are treated as synchronous to clk. No internal input registering beyond the memory write and the dout register.

## Timing
- Write latency: data is visible to a read issued on the following edge, which gives dout one cycle after that read edge.
- Read latency: 1 clock. Address presented before edge N gives valid dout after edge N.
- rst_n low asserts asynchronously and forces dout = 0 immediately. dout stays 0 while rst_n=0. Memory writes are blocked while rst_n=0.
- rst_n deassertion should be synchronous to clk (synchronized externally). The first access is accepted at the first rising edge with rst_n=1.
- Reset mid-operation: any access in progress at the edge coincident with reset assertion is discarded. Memory contents are retained across reset.
- All outputs: dout reset value = {WD{1'b0}}.
- Back-to-back accesses need no bubble cycles:
  - write→read to the same address returns the new data.
  - read→write: dout keeps the read result.

## Test plan
- Reset: assert rst_n=0 with dout previously 0x5A → dout becomes 0x00 asynchronously and stays 0x00 until the first read after release.
- Sequential fill: cs_n=0, w_r_n=1, write addr k ← 0xA0+k for k=0…15 on consecutive edges. Then w_r_n=0 and read addr 15 down to 0 → dout = 0xAF, 0xAE, …, 0xA0, each one cycle after its address.
- Chip deselect: after reading 0xA5 from addr 5, set cs_n=1 and drive w_r_n=1, addr=5, din=0xFF for several cycles → dout holds 0xA5 and a later read of addr 5 still returns 0xA5.
- Write does not disturb dout: read addr 3 (dout=0xA3), then write addr 3 ← 0x3C → dout stays 0xA3. The next read of addr 3 returns 0x3C.
- Back-to-back: write addr 15 ← 0x77, then read addr 15 on the very next edge → dout = 0x77 one cycle later.
- Reset retention: write addr 9 ← 0x99, pulse rst_n low for 2 cycles, then read addr 9 → dout = 0x99.
